// File: rtl/ccr_branch_unit.sv
// Condition-code register with masked NZVC capture, carry feedback to the ALU,
// a LIFO shadow stack for interrupt entry/return, and a 1-cycle branch resolver.
module ccr_branch_unit #(
  parameter int STK_DEPTH = 4,
  parameter int STK_AW    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        ALU_NZVC,
  input  logic              FLAG_WE,
  input  logic [3:0]        FLAG_MASK,
  input  logic              FLAG_SAVE,
  input  logic              FLAG_RESTORE,
  input  logic              BR_REQ,
  input  logic [3:0]        BR_COND,
  output logic [3:0]        NZVC,
  output logic              CIN_CTRL,
  output logic              BR_VALID,
  output logic              BR_TAKEN,
  output logic [STK_AW:0]   STK_COUNT,
  output logic              STK_FULL,
  output logic              STK_EMPTY,
  output logic              STK_ERR,
  output logic              br_state_dbg
);

  typedef enum logic {BR_IDLE = 1'b0, BR_RESP = 1'b1} br_state_t;

  localparam logic [STK_AW:0] DEPTH_C = (STK_AW+1)'(STK_DEPTH);

  logic [3:0]        ccr_q;
  logic [3:0]        ccr_d;
  logic [STK_AW:0]   cnt_q;
  logic              err_q;
  logic [3:0]        stk_mem [STK_DEPTH];
  logic [STK_AW-1:0] push_idx;
  logic [STK_AW-1:0] top_idx;
  logic              push_ok;
  logic              pop_ok;
  logic              stk_fault;

  br_state_t         br_state_q;
  br_state_t         br_state_d;
  logic [3:0]        cond_q;
  logic              taken_q;
  logic              taken_now;

  assign push_idx  = cnt_q[STK_AW-1:0];
  assign top_idx   = push_idx - STK_AW'(1);
  assign STK_FULL  = (cnt_q == DEPTH_C);
  assign STK_EMPTY = (cnt_q == '0);

  // Simultaneous save+restore is ambiguous, so both are refused and flagged.
  assign push_ok   = FLAG_SAVE && !FLAG_RESTORE && !STK_FULL;
  assign pop_ok    = FLAG_RESTORE && !FLAG_SAVE && !STK_EMPTY;
  assign stk_fault = (FLAG_SAVE && FLAG_RESTORE) ||
                     (FLAG_SAVE && STK_FULL) ||
                     (FLAG_RESTORE && STK_EMPTY);

  always_comb begin
    ccr_d = ccr_q;
    if (pop_ok)
      ccr_d = stk_mem[top_idx];
    else if (FLAG_WE)
      ccr_d = (FLAG_MASK & ALU_NZVC) | (~FLAG_MASK & ccr_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ccr_q <= 4'b0000;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ccr_q <= ccr_d;
      if (push_ok)
        cnt_q <= cnt_q + 1'b1;
      else if (pop_ok)
        cnt_q <= cnt_q - 1'b1;
      if (stk_fault)
        err_q <= 1'b1;
    end
  end

  // A push captures the pre-write CCR even when FLAG_WE updates it in the same cycle.
  always_ff @(posedge CLK) begin
    if (push_ok)
      stk_mem[push_idx] <= ccr_q;
  end

  assign NZVC      = ccr_q;
  assign CIN_CTRL  = ccr_q[0];
  assign STK_COUNT = cnt_q;
  assign STK_ERR   = err_q;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    n  = f[3];
    z  = f[2];
    v  = f[1];
    cy = f[0];
    case (c)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = cy;
      4'h3:    cond_eval = !cy;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = cy && !z;
      4'h9:    cond_eval = !cy || z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z && (n == v);
      4'hD:    cond_eval = z || (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Branch handshake: BR_REQ is a 1-cycle pulse sampled with BR_COND at a rising
  // edge; BR_VALID is high for exactly the following cycle, with BR_TAKEN computed
  // from the CCR as updated by that same edge. No back-pressure; BR_TAKEN then holds.
  assign taken_now = cond_eval(cond_q, ccr_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_state_q <= BR_IDLE;
      cond_q     <= 4'h0;
      taken_q    <= 1'b0;
    end else begin
      br_state_q <= br_state_d;
      if (BR_REQ)
        cond_q <= BR_COND;
      if (br_state_q == BR_RESP)
        taken_q <= taken_now;
    end
  end

  always_comb begin
    br_state_d = br_state_q;
    BR_VALID   = 1'b0;
    BR_TAKEN   = taken_q;
    case (br_state_q)
      BR_IDLE: begin
        if (BR_REQ)
          br_state_d = BR_RESP;
      end
      BR_RESP: begin
        BR_VALID = 1'b1;
        BR_TAKEN = taken_now;
        if (!BR_REQ)
          br_state_d = BR_IDLE;
      end
      default: br_state_d = BR_IDLE;
    endcase
  end

  assign br_state_dbg = br_state_q;

endmodule
